// File: rtl/ov7670_fb_pkg.sv
// Shared state encoding, scale-mode constants and channel expansion helper
// for the OV7670 frame-buffer writer.
package ov7670_fb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE       = 2'd0,
      ST_WAIT_FRAME = 2'd1,
      ST_CAPTURE    = 2'd2
   } fb_state_t;

   localparam logic [1:0] SCALE_1X      = 2'd0;
   localparam logic [1:0] SCALE_HALF    = 2'd1;
   localparam logic [1:0] SCALE_QUARTER = 2'd2;
   localparam logic [1:0] SCALE_ALIAS   = 2'd3;

   // Mode 3 behaves exactly like quarter scale.
   function automatic logic [1:0] norm_scale(input logic [1:0] s);
      return (s == SCALE_ALIAS) ? SCALE_QUARTER : s;
   endfunction

   // Widen a w-bit channel (right-aligned in v) to 8 bits by repeating its MSBs.
   function automatic logic [7:0] expand8(input logic [7:0] v, input int w);
      logic [7:0] r;
      r = '0;
      for (int i = 0; i < 8; i++) begin
         r[7-i] = v[w-1-(i%w)];
      end
      return r;
   endfunction

endpackage

// File: rtl/ov7670_px_convert.sv
// Combinational pixel conversion: expand RGB to 8 bits, optional luma,
// truncate each channel to OUT_CH_WIDTH bits.
module ov7670_px_convert #(
   parameter int R_WIDTH      = 5,
   parameter int G_WIDTH      = 6,
   parameter int B_WIDTH      = 5,
   parameter int PXL_WIDTH    = R_WIDTH + G_WIDTH + B_WIDTH,
   parameter int OUT_CH_WIDTH = 4
) (
   input  logic                      gray,
   input  logic [PXL_WIDTH-1:0]      pixel,
   output logic [3*OUT_CH_WIDTH-1:0] data
);
   import ov7670_fb_pkg::*;

   logic [R_WIDTH-1:0] r;
   logic [G_WIDTH-1:0] g;
   logic [B_WIDTH-1:0] b;
   logic [7:0]         r8;
   logic [7:0]         g8;
   logic [7:0]         b8;
   logic [9:0]         sum;
   logic [7:0]         y;
   logic               unused_bits;

   assign r = pixel[PXL_WIDTH-1 -: R_WIDTH];
   assign g = pixel[B_WIDTH +: G_WIDTH];
   assign b = pixel[B_WIDTH-1:0];

   assign r8 = expand8(8'(r), R_WIDTH);
   assign g8 = expand8(8'(g), G_WIDTH);
   assign b8 = expand8(8'(b), B_WIDTH);

   // Green weighted twice; the 10-bit sum cannot overflow (max 4*255).
   assign sum = 10'(r8) + (10'(g8) << 1) + 10'(b8);
   assign y   = sum[9:2];

   always_comb begin
      data = '0;
      if (gray) begin
         data = {y[7 -: OUT_CH_WIDTH], y[7 -: OUT_CH_WIDTH], y[7 -: OUT_CH_WIDTH]};
      end else begin
         data = {r8[7 -: OUT_CH_WIDTH], g8[7 -: OUT_CH_WIDTH], b8[7 -: OUT_CH_WIDTH]};
      end
   end

   assign unused_bits = ^{r8, g8, b8, sum};

endmodule

// File: rtl/ov7670_fb_writer.sv
// Frame-buffer write engine: accepts camera pixels, decimates/converts them and
// issues linear BRAM writes one cycle later, with arm/done/error handshakes.
module ov7670_fb_writer #(
   parameter int H_WIDTH      = 640,
   parameter int V_WIDTH      = 480,
   parameter int R_WIDTH      = 5,
   parameter int G_WIDTH      = 6,
   parameter int B_WIDTH      = 5,
   parameter int PXL_WIDTH    = R_WIDTH + G_WIDTH + B_WIDTH,
   parameter int OUT_CH_WIDTH = 4,
   parameter int ADDR_WIDTH   = 19
) (
   input  logic                      i_clk,
   input  logic                      i_n_reset,
   input  logic                      i_arm,
   input  logic                      i_continuous,
   input  logic [1:0]                i_scale,
   input  logic                      i_gray,
   input  logic                      i_frame_start,
   input  logic                      i_valid,
   input  logic [10:0]               i_h_addr,
   input  logic [9:0]                i_v_addr,
   input  logic [PXL_WIDTH-1:0]      i_pixel_data,
   output logic                      o_wr_en,
   output logic [ADDR_WIDTH-1:0]     o_wr_addr,
   output logic [3*OUT_CH_WIDTH-1:0] o_wr_data,
   output logic                      o_busy,
   output logic                      o_frame_done,
   output logic                      o_frame_error
);
   import ov7670_fb_pkg::*;

   localparam int N_1X      = H_WIDTH * V_WIDTH;
   localparam int N_HALF    = (H_WIDTH >> 1) * (V_WIDTH >> 1);
   localparam int N_QUARTER = (H_WIDTH >> 2) * (V_WIDTH >> 2);
   localparam logic [10:0] H_LIM = 11'(H_WIDTH);
   localparam logic [9:0]  V_LIM = 10'(V_WIDTH);

   fb_state_t state_q;
   fb_state_t state_d;

   logic [ADDR_WIDTH-1:0]     cnt_q;
   logic [ADDR_WIDTH:0]       n_last_q;
   logic [ADDR_WIDTH:0]       n_last_d;
   logic [1:0]                scale_q;
   logic [1:0]                scale_d;
   logic                      gray_q;
   logic                      sat_q;
   logic [1:0]                align_mask;
   logic                      in_range;
   logic                      aligned;
   logic                      pix_ok;
   logic                      last;
   logic                      latch_mode;
   logic                      accept;
   logic                      done;
   logic                      restart;
   logic [3*OUT_CH_WIDTH-1:0] conv_data;

   ov7670_px_convert #(
      .R_WIDTH      (R_WIDTH),
      .G_WIDTH      (G_WIDTH),
      .B_WIDTH      (B_WIDTH),
      .PXL_WIDTH    (PXL_WIDTH),
      .OUT_CH_WIDTH (OUT_CH_WIDTH)
   ) u_convert (
      .gray  (gray_q),
      .pixel (i_pixel_data),
      .data  (conv_data)
   );

   // Decimation keeps only pixels whose low s bits of row and column are zero.
   always_comb begin
      align_mask = 2'b00;
      case (scale_q)
         SCALE_HALF:    align_mask = 2'b01;
         SCALE_QUARTER: align_mask = 2'b11;
         default:       align_mask = 2'b00;
      endcase
   end

   assign in_range = (i_h_addr < H_LIM) && (i_v_addr < V_LIM);
   assign aligned  = ((i_h_addr[1:0] | i_v_addr[1:0]) & align_mask) == 2'b00;
   assign pix_ok   = i_valid && in_range && aligned;
   assign last     = ({1'b0, cnt_q} == n_last_q);

   assign scale_d = norm_scale(i_scale);

   always_comb begin
      n_last_d = (ADDR_WIDTH+1)'(N_1X - 1);
      case (scale_d)
         SCALE_HALF:    n_last_d = (ADDR_WIDTH+1)'(N_HALF - 1);
         SCALE_QUARTER: n_last_d = (ADDR_WIDTH+1)'(N_QUARTER - 1);
         default:       n_last_d = (ADDR_WIDTH+1)'(N_1X - 1);
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!i_n_reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      latch_mode = 1'b0;
      accept     = 1'b0;
      done       = 1'b0;
      restart    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (i_arm) begin
               state_d = ST_WAIT_FRAME;
            end
         end
         ST_WAIT_FRAME: begin
            if (i_frame_start) begin
               state_d    = ST_CAPTURE;
               latch_mode = 1'b1;
            end
         end
         ST_CAPTURE: begin
            // A new VS before completion restarts the frame; no write that cycle.
            if (i_frame_start) begin
               restart    = 1'b1;
               latch_mode = 1'b1;
            end else if (pix_ok && !sat_q) begin
               accept = 1'b1;
               if (last) begin
                  done    = 1'b1;
                  state_d = i_continuous ? ST_WAIT_FRAME : ST_IDLE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!i_n_reset) begin
         o_wr_en       <= 1'b0;
         o_wr_addr     <= '0;
         o_wr_data     <= '0;
         o_busy        <= 1'b0;
         o_frame_done  <= 1'b0;
         o_frame_error <= 1'b0;
         cnt_q         <= '0;
         n_last_q      <= '0;
         scale_q       <= SCALE_1X;
         gray_q        <= 1'b0;
         sat_q         <= 1'b0;
      end else begin
         o_wr_en       <= accept;
         o_frame_done  <= done;
         o_frame_error <= restart;
         o_busy        <= (state_d != ST_IDLE);
         if (accept) begin
            o_wr_addr <= cnt_q;
            o_wr_data <= conv_data;
            cnt_q     <= cnt_q + 1'b1;
            if (cnt_q == '1) begin
               sat_q <= 1'b1;
            end
         end
         if (latch_mode) begin
            scale_q  <= scale_d;
            gray_q   <= i_gray;
            n_last_q <= n_last_d;
            cnt_q    <= '0;
            sat_q    <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_ov7670_fb_writer.sv
// Directed bench for ov7670_fb_writer on a reduced 40x30 frame.
module tb_ov7670_fb_writer;

   localparam int H  = 40;
   localparam int V  = 30;
   localparam int AW = 11;
   localparam int OW = 4;

   logic          i_clk = 1'b0;
   logic          i_n_reset;
   logic          i_arm;
   logic          i_continuous;
   logic [1:0]    i_scale;
   logic          i_gray;
   logic          i_frame_start;
   logic          i_valid;
   logic [10:0]   i_h_addr;
   logic [9:0]    i_v_addr;
   logic [15:0]   i_pixel_data;
   logic          o_wr_en;
   logic [AW-1:0] o_wr_addr;
   logic [3*OW-1:0] o_wr_data;
   logic          o_busy;
   logic          o_frame_done;
   logic          o_frame_error;

   int checks = 0;
   int errors = 0;

   ov7670_fb_writer #(
      .H_WIDTH      (H),
      .V_WIDTH      (V),
      .R_WIDTH      (5),
      .G_WIDTH      (6),
      .B_WIDTH      (5),
      .PXL_WIDTH    (16),
      .OUT_CH_WIDTH (OW),
      .ADDR_WIDTH   (AW)
   ) dut (
      .i_clk         (i_clk),
      .i_n_reset     (i_n_reset),
      .i_arm         (i_arm),
      .i_continuous  (i_continuous),
      .i_scale       (i_scale),
      .i_gray        (i_gray),
      .i_frame_start (i_frame_start),
      .i_valid       (i_valid),
      .i_h_addr      (i_h_addr),
      .i_v_addr      (i_v_addr),
      .i_pixel_data  (i_pixel_data),
      .o_wr_en       (o_wr_en),
      .o_wr_addr     (o_wr_addr),
      .o_wr_data     (o_wr_data),
      .o_busy        (o_busy),
      .o_frame_done  (o_frame_done),
      .o_frame_error (o_frame_error)
   );

   always #5 i_clk = ~i_clk;

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic clear_inputs();
      i_arm = 1'b0; i_continuous = 1'b0; i_scale = 2'd0; i_gray = 1'b0;
      i_frame_start = 1'b0; i_valid = 1'b0; i_h_addr = '0; i_v_addr = '0;
      i_pixel_data = '0;
   endtask

   task automatic do_reset();
      clear_inputs();
      i_n_reset = 1'b0;
      tick(); tick();
      i_n_reset = 1'b1;
   endtask

   task automatic start_capture(input logic [1:0] s, input logic g, input logic c);
      i_continuous = c;
      i_arm = 1'b1;
      tick();
      i_arm = 1'b0;
      i_scale = s; i_gray = g; i_frame_start = 1'b1;
      tick();
      i_frame_start = 1'b0;
   endtask

   // Present one pixel and advance one edge; outputs then reflect this pixel.
   task automatic drive_pix(input int h, input int v, input logic [15:0] d);
      i_valid = 1'b1; i_h_addr = 11'(h); i_v_addr = 10'(v); i_pixel_data = d;
      tick();
      i_valid = 1'b0;
   endtask

   task automatic test_reset();
      clear_inputs();
      i_valid = 1'b1; i_arm = 1'b1; i_frame_start = 1'b1; i_pixel_data = 16'hFFFF;
      i_n_reset = 1'b0;
      tick(); tick();
      checks++;
      if (o_wr_en !== 1'b0 || o_wr_addr !== '0 || o_wr_data !== '0 || o_busy !== 1'b0 ||
          o_frame_done !== 1'b0 || o_frame_error !== 1'b0) begin
         errors++;
         $display("FAIL reset_outputs: en=%b addr=%0d data=%h busy=%b done=%b err=%b, required all 0",
                  o_wr_en, o_wr_addr, o_wr_data, o_busy, o_frame_done, o_frame_error);
      end
      clear_inputs();
      i_n_reset = 1'b1;
   endtask

   task automatic test_full_frame();
      int exp_addr = 0;
      int dones = 0;
      do_reset();
      start_capture(2'd0, 1'b0, 1'b0);
      i_scale = 2'd1; i_gray = 1'b1;   // must not affect the running frame
      for (int v = 0; v < V; v++) begin
         for (int h = 0; h < H; h++) begin
            drive_pix(h, v, 16'hF800);
            checks++;
            if (o_wr_en !== 1'b1 || o_wr_addr !== AW'(exp_addr) || o_wr_data !== 12'hF00 ||
                o_frame_done !== (exp_addr == H*V-1)) begin
               errors++;
               $display("FAIL full_frame h=%0d v=%0d: en=%b addr=%0d data=%h done=%b, required en=1 addr=%0d data=f00 done=%b",
                        h, v, o_wr_en, o_wr_addr, o_wr_data, o_frame_done, exp_addr, exp_addr == H*V-1);
            end
            if (o_frame_done === 1'b1) dones++;
            exp_addr++;
         end
      end
      checks++;
      if (dones !== 1) begin
         errors++;
         $display("FAIL full_frame_done_count: got %0d, required 1", dones);
      end
      drive_pix(0, 0, 16'hF800);
      checks++;
      if (o_wr_en !== 1'b0 || o_busy !== 1'b0) begin
         errors++;
         $display("FAIL full_frame_idle: en=%b busy=%b, required 0 0", o_wr_en, o_busy);
      end
   endtask

   task automatic test_scale_half();
      int exp_addr = 0;
      int dones = 0;
      do_reset();
      start_capture(2'd1, 1'b0, 1'b0);
      for (int v = 0; v < V; v++) begin
         for (int h = 0; h < H; h++) begin
            drive_pix(h, v, 16'h07E0);
            if ((h % 2) == 1 || (v % 2) == 1) begin
               checks++;
               if (o_wr_en !== 1'b0) begin
                  errors++;
                  $display("FAIL half_odd_skip h=%0d v=%0d: en=%b, required 0", h, v, o_wr_en);
               end
            end else begin
               checks++;
               if (o_wr_en !== 1'b1 || o_wr_addr !== AW'(exp_addr) ||
                   o_frame_done !== (exp_addr == 299)) begin
                  errors++;
                  $display("FAIL half_write h=%0d v=%0d: en=%b addr=%0d done=%b, required en=1 addr=%0d done=%b",
                           h, v, o_wr_en, o_wr_addr, o_frame_done, exp_addr, exp_addr == 299);
               end
               if (h == 2 && v == 2) begin
                  checks++;
                  if (o_wr_addr !== AW'(21)) begin
                     errors++;
                     $display("FAIL half_pixel_2_2: addr=%0d, required 21", o_wr_addr);
                  end
               end
               exp_addr++;
            end
            if (o_frame_done === 1'b1) dones++;
         end
      end
      checks++;
      if (exp_addr !== 300 || dones !== 1) begin
         errors++;
         $display("FAIL half_totals: writes=%0d dones=%0d, required 300 1", exp_addr, dones);
      end
   endtask

   // Scale code 3 acts as quarter: N = 10*7 = 70, finishing on row 24.
   task automatic test_scale_quarter_alias();
      int writes = 0;
      int dones = 0;
      do_reset();
      start_capture(2'd3, 1'b0, 1'b0);
      for (int v = 0; v < V; v++) begin
         for (int h = 0; h < H; h++) begin
            drive_pix(h, v, 16'h001F);
            if (o_wr_en === 1'b1) begin
               checks++;
               if ((h % 4) != 0 || (v % 4) != 0 || o_wr_addr !== AW'(writes) || v > 24) begin
                  errors++;
                  $display("FAIL quarter_write h=%0d v=%0d: addr=%0d, required aligned pixel at addr %0d",
                           h, v, o_wr_addr, writes);
               end
               writes++;
            end
            if (o_frame_done === 1'b1) dones++;
         end
      end
      checks++;
      if (writes !== 70 || dones !== 1) begin
         errors++;
         $display("FAIL quarter_totals: writes=%0d dones=%0d, required 70 1", writes, dones);
      end
   endtask

   task automatic test_color();
      logic [15:0] pix [4] = '{16'hF800, 16'h07E0, 16'h001F, 16'h8410};
      logic [11:0] rgb [4] = '{12'hF00, 12'h0F0, 12'h00F, 12'h888};
      logic [11:0] gry [4] = '{12'h333, 12'h777, 12'h333, 12'h888};
      do_reset();
      start_capture(2'd0, 1'b0, 1'b0);
      for (int k = 0; k < 4; k++) begin
         drive_pix(k, 0, pix[k]);
         checks++;
         if (o_wr_en !== 1'b1 || o_wr_data !== rgb[k]) begin
            errors++;
            $display("FAIL color_rgb[%0d]: en=%b data=%h, required 1 %h", k, o_wr_en, o_wr_data, rgb[k]);
         end
      end
      i_gray = 1'b1;
      drive_pix(4, 0, 16'hF800);
      checks++;
      if (o_wr_data !== 12'hF00) begin
         errors++;
         $display("FAIL color_gray_not_latched: data=%h, required f00", o_wr_data);
      end
      i_frame_start = 1'b1;
      tick();
      i_frame_start = 1'b0;
      for (int k = 0; k < 4; k++) begin
         drive_pix(k, 0, pix[k]);
         checks++;
         if (o_wr_en !== 1'b1 || o_wr_data !== gry[k] || o_wr_addr !== AW'(k)) begin
            errors++;
            $display("FAIL color_gray[%0d]: en=%b addr=%0d data=%h, required 1 %0d %h",
                     k, o_wr_en, o_wr_addr, o_wr_data, k, gry[k]);
         end
      end
   endtask

   task automatic test_frame_error();
      do_reset();
      start_capture(2'd0, 1'b0, 1'b0);
      for (int k = 0; k < 1000; k++) begin
         drive_pix(k % H, k / H, 16'h1234);
      end
      checks++;
      if (o_wr_addr !== AW'(999) || o_frame_error !== 1'b0) begin
         errors++;
         $display("FAIL error_pre: addr=%0d err=%b, required 999 0", o_wr_addr, o_frame_error);
      end
      i_frame_start = 1'b1;
      tick();
      i_frame_start = 1'b0;
      checks++;
      if (o_frame_error !== 1'b1 || o_wr_en !== 1'b0 || o_busy !== 1'b1) begin
         errors++;
         $display("FAIL error_pulse: err=%b en=%b busy=%b, required 1 0 1", o_frame_error, o_wr_en, o_busy);
      end
      drive_pix(0, 0, 16'h1234);
      checks++;
      if (o_frame_error !== 1'b0 || o_wr_en !== 1'b1 || o_wr_addr !== '0) begin
         errors++;
         $display("FAIL error_restart: err=%b en=%b addr=%0d, required 0 1 0", o_frame_error, o_wr_en, o_wr_addr);
      end
   endtask

   task automatic test_continuous();
      int dones = 0;
      int writes = 0;
      int busy_low = 0;
      do_reset();
      i_continuous = 1'b1;
      i_arm = 1'b1;
      tick();
      i_arm = 1'b0;
      for (int f = 0; f < 2; f++) begin
         i_scale = 2'd2;
         i_frame_start = 1'b1;
         tick();
         i_frame_start = 1'b0;
         if (o_busy !== 1'b1) busy_low++;
         for (int v = 0; v < V; v++) begin
            for (int h = 0; h < H; h++) begin
               drive_pix(h, v, 16'hFFFF);
               if (o_busy !== 1'b1) busy_low++;
               if (o_wr_en === 1'b1) writes++;
               if (o_frame_done === 1'b1) dones++;
            end
         end
      end
      checks++;
      if (dones !== 2 || writes !== 140) begin
         errors++;
         $display("FAIL continuous_frames: dones=%0d writes=%0d, required 2 140", dones, writes);
      end
      checks++;
      if (busy_low !== 0) begin
         errors++;
         $display("FAIL continuous_busy: busy low on %0d cycles, required 0", busy_low);
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      start_capture(2'd0, 1'b0, 1'b0);
      drive_pix(0, 0, 16'hFFFF);
      i_n_reset = 1'b0;
      drive_pix(1, 0, 16'hFFFF);
      checks++;
      if (o_wr_en !== 1'b0 || o_wr_addr !== '0 || o_wr_data !== '0 || o_busy !== 1'b0 ||
          o_frame_done !== 1'b0 || o_frame_error !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid: en=%b addr=%0d data=%h busy=%b done=%b err=%b, required all 0",
                  o_wr_en, o_wr_addr, o_wr_data, o_busy, o_frame_done, o_frame_error);
      end
      i_n_reset = 1'b1;
      drive_pix(2, 0, 16'hFFFF);
      checks++;
      if (o_wr_en !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid_idle: en=%b, required 0", o_wr_en);
      end
      // Arm and VS together from IDLE only arms; capture waits for the next VS.
      i_arm = 1'b1; i_frame_start = 1'b1;
      tick();
      i_arm = 1'b0; i_frame_start = 1'b0;
      drive_pix(0, 0, 16'hF800);
      checks++;
      if (o_wr_en !== 1'b0 || o_busy !== 1'b1) begin
         errors++;
         $display("FAIL arm_vs_coincident: en=%b busy=%b, required 0 1", o_wr_en, o_busy);
      end
      i_frame_start = 1'b1;
      tick();
      i_frame_start = 1'b0;
      drive_pix(0, 0, 16'hF800);
      checks++;
      if (o_wr_en !== 1'b1 || o_wr_addr !== '0 || o_wr_data !== 12'hF00) begin
         errors++;
         $display("FAIL arm_vs_capture: en=%b addr=%0d data=%h, required 1 0 f00", o_wr_en, o_wr_addr, o_wr_data);
      end
   endtask

   initial begin
      clear_inputs();
      i_n_reset = 1'b0;
      test_reset();
      test_full_frame();
      test_scale_half();
      test_scale_quarter_alias();
      test_color();
      test_frame_error();
      test_continuous();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
